ps2_key_encoder: RTL and testbench

// - Produces the 11-bit ps2_key event word {toggle, pressed, extended, code[7:0]} from raw PS/2 keyboard lines.
// - Sits between the keyboard pins (or the USER_IN pins) and the core's key decoder.
// - The decoder detects a new event as a change in bit 10, and reads bit 9 as pressed and bits 8:0 as the code.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_key_encoder_if.sv | 14 +
 rtl/ps2_frame_rx.sv | 136 +++++++++++++
 rtl/ps2_key_encoder.sv | 91 +++++++++
 tb/tb_ps2_key_encoder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 key encoder
// Purpose: frame FSM state enum, scan-code prefix and ignore-list constants,
//          ps2_key field offsets and the ignore-list helper.
// Ports:   none (package).
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;

  // Keyboard status/response bytes that never carry a key event on their own
  localparam logic [7:0] IGN_ACK    = 8'hFA;
  localparam logic [7:0] IGN_BAT    = 8'hAA;
  localparam logic [7:0] IGN_ECHO   = 8'hEE;
  localparam logic [7:0] IGN_RESEND = 8'hFE;
  localparam logic [7:0] IGN_ERR0   = 8'h00;
  localparam logic [7:0] IGN_ERR1   = 8'hFF;

  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == IGN_ACK) || (b == IGN_BAT) || (b == IGN_ECHO) ||
           (b == IGN_RESEND) || (b == IGN_ERR0) || (b == IGN_ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_encoder_if.sv
// rtl/ps2_key_encoder_if.sv - key event / debug output bundle of the encoder
// Purpose: carries the ps2_key event word and the receiver status outputs.
// Signals: ps2_key[10:0] {toggle, pressed, ext, code}, frame_err pulse,
//          rx_byte[7:0] last good byte, rx_stb pulse on rx_byte update.
// Modports: master = encoder (drives), slave = consumer (key decoder).
interface ps2_key_encoder_if;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic [7:0]  rx_byte;
  logic        rx_stb;

  modport master (output ps2_key, output frame_err, output rx_byte, output rx_stb);
  modport slave  (input  ps2_key, input  frame_err, input  rx_byte, input  rx_stb);
endinterface

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 line synchroniser, clock filter and frame receiver
// Purpose: turns the raw asynchronous PS/2 lines into checked bytes.
// Ports:   clk_sys, reset_n (async active-low), ps2_clk_i, ps2_dat_i raw lines;
//          rx_byte_o good byte, rx_stb_o one-cycle byte strobe,
//          frame_err_o one-cycle pulse on parity/start/stop/timeout error.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 4800
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_stb_o,
  output logic       frame_err_o
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             filt_q, filt_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  rx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       byte_q, byte_d;
  logic             stb_q, stb_d;
  logic             err_q, err_d;

  logic clk_s, dat_s, strobe, timeout;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // Filter: the level follows the synchronised line only after FILTER_LEN
  // consecutive differing samples; a 1->0 change is the bit strobe.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    strobe    = 1'b0;
    if (clk_s != filt_q) begin
      if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
        strobe = filt_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  assign timeout = (state_q != IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    byte_d    = byte_q;
    stb_d     = 1'b0;
    err_d     = 1'b0;
    tmo_d     = (state_q == IDLE || strobe) ? '0 : tmo_q + 1'b1;
    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (strobe) begin
      case (state_q)
        IDLE: begin
          if (!dat_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          if (dat_s && (^{shift_q, par_q})) begin
            byte_d = shift_q;
            stb_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      filt_q     <= 1'b0;
      flt_cnt_q  <= '0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      byte_q     <= '0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      filt_q     <= filt_d;
      flt_cnt_q  <= flt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      byte_q     <= byte_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
    end
  end

  assign rx_byte_o   = byte_q;
  assign rx_stb_o    = stb_q;
  assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_key_encoder.sv
// rtl/ps2_key_encoder.sv - PS/2 keyboard to ps2_key event word encoder
// Purpose: decodes E0/F0/E1 prefixes from received bytes and maintains the
//          11-bit ps2_key word whose bit 10 toggles once per key event.
// Ports:   clk_sys, reset_n (async active-low), ps2_clk_i, ps2_dat_i raw lines;
//          key_if (master): ps2_key, frame_err, rx_byte, rx_stb.
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 4800,
  parameter int PAUSE_SKIP  = 7
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ps2_clk_i,
  input  logic               ps2_dat_i,
  ps2_key_encoder_if.master  key_if
);

  localparam int SKIP_W = $clog2(PAUSE_SKIP + 1);

  logic [7:0]        rx_byte;
  logic              rx_stb, frame_err;
  logic [10:0]       key_q, key_d;
  logic              ext_q, ext_d, rel_q, rel_d;
  logic [SKIP_W-1:0] skip_q, skip_d;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_dat_i   (ps2_dat_i),
    .rx_byte_o   (rx_byte),
    .rx_stb_o    (rx_stb),
    .frame_err_o (frame_err)
  );

  always_comb begin
    key_d  = key_q;
    ext_d  = ext_q;
    rel_d  = rel_q;
    skip_d = skip_q;
    if (frame_err) begin
      // A broken frame may have been a prefix; never let it bind to a later code.
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (rx_stb) begin
      if (skip_q != '0) begin
        skip_d = skip_q - 1'b1;
      end else if (rx_byte == PFX_E1) begin
        skip_d = SKIP_W'(PAUSE_SKIP);
        ext_d  = 1'b0;
        rel_d  = 1'b0;
      end else if (rx_byte == PFX_E0) begin
        ext_d = 1'b1;
      end else if (rx_byte == PFX_F0) begin
        rel_d = 1'b1;
      end else if (!(is_ignored(rx_byte) && !ext_q && !rel_q)) begin
        key_d[KEY_TOGGLE]  = ~key_q[KEY_TOGGLE];
        key_d[KEY_PRESSED] = ~rel_q;
        key_d[KEY_EXT]     = ext_q;
        key_d[7:0]         = rx_byte;
        ext_d              = 1'b0;
        rel_d              = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      key_q  <= '0;
      ext_q  <= 1'b0;
      rel_q  <= 1'b0;
      skip_q <= '0;
    end else begin
      key_q  <= key_d;
      ext_q  <= ext_d;
      rel_q  <= rel_d;
      skip_q <= skip_d;
    end
  end

  assign key_if.ps2_key   = key_q;
  assign key_if.frame_err = frame_err;
  assign key_if.rx_byte   = rx_byte;
  assign key_if.rx_stb    = rx_stb;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb/tb_ps2_key_encoder.sv - scoreboard bench for ps2_key_encoder
module tb_ps2_key_encoder;

  localparam int HALF        = 40;
  localparam int TIMEOUT_CYC = 4800;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  always #5 clk_sys = ~clk_sys;

  ps2_key_encoder_if key_if ();

  ps2_key_encoder dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk_i (ps2_clk),
    .ps2_dat_i (ps2_dat),
    .key_if    (key_if)
  );

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int err_cyc = 0;
  logic [10:0] key_exp_q[$];
  logic [7:0]  byte_exp_q[$];
  logic [10:0] last_key = '0;
  logic        prev_stb = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected bytes/events whenever the DUT presents them.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      last_key = key_if.ps2_key;
      prev_stb = 1'b0;
    end else begin
      if (key_if.frame_err) begin
        err_seen++;
        err_cyc = cyc;
      end
      if (key_if.rx_stb) begin
        int exp_b;
        exp_b = 256;
        if (byte_exp_q.size() > 0) exp_b = int'(byte_exp_q.pop_front());
        check("rx_byte", int'(key_if.rx_byte), exp_b);
      end
      if (key_if.ps2_key != last_key) begin
        int exp_k;
        exp_k = 'h800;
        if (key_exp_q.size() > 0) exp_k = int'(key_exp_q.pop_front());
        check("key_one_cycle_after_stb", int'(prev_stb), 1);
        check("ps2_key", int'(key_if.ps2_key), exp_k);
        last_key = key_if.ps2_key;
      end
      prev_stb = key_if.rx_stb;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(1'b1);
    ps2_dat = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic good(input logic [7:0] b);
    byte_exp_q.push_back(b);
    send_frame(b, 1'b0);
  endtask

  task automatic ev(input logic [7:0] b, input logic [10:0] k);
    key_exp_q.push_back(k);
    good(b);
  endtask

  task automatic do_reset();
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    reset_n = 1'b0;
    wait_cyc(3);
    check("reset_ps2_key", int'(key_if.ps2_key), 0);
    check("reset_frame_err", int'(key_if.frame_err), 0);
    check("reset_rx_byte", int'(key_if.rx_byte), 0);
    check("reset_rx_stb", int'(key_if.rx_stb), 0);
    reset_n = 1'b1;
    wait_cyc(50);
    err_seen = 0;
  endtask

  task automatic end_test(input int exp_err);
    wait_cyc(200);
    check("missing_events", key_exp_q.size(), 0);
    check("missing_bytes", byte_exp_q.size(), 0);
    check("frame_err_count", err_seen, exp_err);
    key_exp_q.delete();
    byte_exp_q.delete();
  endtask

  initial begin
    int d;
    #1;
    // Make / break of a plain key
    do_reset();
    ev(8'h29, 11'h629);
    good(8'hF0);
    ev(8'h29, 11'h029);
    end_test(0);

    // Extended key make / break
    do_reset();
    good(8'hE0);
    ev(8'h75, 11'h775);
    good(8'hE0);
    good(8'hF0);
    ev(8'h75, 11'h175);
    end_test(0);

    // Parity error drops the frame and any pending prefix
    do_reset();
    good(8'hF0);
    send_frame(8'h55, 1'b1);
    ev(8'h1C, 11'h61C);
    end_test(1);

    // Clock stops mid-frame
    do_reset();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_dat = 1'b1;
    wait_cyc(7200);
    check("timeout_err", err_seen, 1);
    d = err_cyc - last_fall_cyc;
    check("timeout_delay_in_window", int'(d >= TIMEOUT_CYC && d <= TIMEOUT_CYC + 30), 1);
    ev(8'h16, 11'h616);
    end_test(1);

    // Pause sequence is swallowed
    do_reset();
    good(8'hE1);
    good(8'h14);
    good(8'h77);
    good(8'hE1);
    good(8'hF0);
    good(8'h14);
    good(8'hF0);
    good(8'h77);
    ev(8'h05, 11'h605);
    end_test(0);

    // Ignored status byte, clock glitch in IDLE, reset mid-frame
    do_reset();
    good(8'hFA);
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(20);
    ps2_dat = 1'b1;
    wait_cyc(50);
    ev(8'h2B, 11'h62B);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset_n = 1'b0;
    wait_cyc(2);
    check("midframe_reset_ps2_key", int'(key_if.ps2_key), 0);
    reset_n = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(50);
    ev(8'h34, 11'h634);
    end_test(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
